// File: rtl/cavlc_level_encode.sv
// cavlc_level_encode
// Turns the nonzero levels of one 4x4 block into CAVLC trailing-one sign bits
// and level_prefix/level_suffix codewords. The baseline 12-bit escape is used.
// Each codeword is emitted right-justified over a valid/ready handshake.
module cavlc_level_encode #(
   parameter int unsigned MAX_SUFFIX_LEN = 6
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [4:0]  TotalCoeff,
   input  logic [1:0]  TrailingOnes,
   input  logic [12:0] LevelIn,
   input  logic        LevelValid,
   output logic        LevelRdy,
   output logic [27:0] CodeOut,
   output logic [4:0]  CodeLen,
   output logic        CodeValid,
   input  logic        CodeReady,
   output logic        Busy,
   output logic        Done,
   output logic        LevelErr
);

   localparam logic [2:0] SL_MAX = 3'(MAX_SUFFIX_LEN);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t      state;
   logic [4:0]  tc;
   logic [4:0]  cnt;
   logic [1:0]  t1;
   logic [2:0]  sl;

   logic        neg;
   logic        is_t1;
   logic        first;
   logic        err;
   logic        take;
   logic [15:0] ext;
   logic [15:0] mag;
   logic [15:0] lc;
   logic [15:0] esc_base;
   logic [15:0] sfx;
   logic [15:0] val;
   logic [15:0] thresh;
   logic [3:0]  prefix;
   logic [3:0]  suflen;
   logic [4:0]  len;
   logic [2:0]  sl_one;
   logic [2:0]  sl_next;

   // A level may enter only while the output register is free or draining this cycle
   assign LevelRdy = (state == RUN) && (cnt < tc) && (!CodeValid || CodeReady);
   assign take     = LevelValid && LevelRdy;

   // Codeword, length, error and next suffixLength for the level on LevelIn
   always_comb begin
      neg      = LevelIn[12];
      ext      = {{3{LevelIn[12]}}, LevelIn};
      mag      = neg ? (~ext + 16'd1) : ext;
      is_t1    = cnt < {3'b000, t1};
      first    = cnt == {3'b000, t1};
      lc       = neg ? ((mag << 1) - 16'd1) : ((mag << 1) - 16'd2);
      if (first && t1 != 2'd3)
         lc = lc - 16'd2;
      esc_base = 16'd15 << sl;
      prefix   = '0;
      suflen   = '0;
      sfx      = '0;
      if (sl == 3'd0) begin
         if (lc < 16'd14) begin
            prefix = lc[3:0];
         end else if (lc < 16'd30) begin
            prefix = 4'd14;
            suflen = 4'd4;
            sfx    = lc - 16'd14;
         end else begin
            prefix = 4'd15;
            suflen = 4'd12;
            sfx    = lc - 16'd30;
         end
      end else begin
         if (lc < esc_base) begin
            prefix = 4'(lc >> sl);
            suflen = {1'b0, sl};
            sfx    = lc & ((16'd1 << sl) - 16'd1);
         end else begin
            prefix = 4'd15;
            suflen = 4'd12;
            sfx    = lc - esc_base;
         end
      end
      val = (16'd1 << suflen) | sfx;
      len = 5'(prefix) + 5'd1 + 5'(suflen);
      if (is_t1) begin
         val = {15'd0, neg};
         len = 5'd1;
         err = mag != 16'd1;
      end else begin
         // A first non-T1 level of +/-1 with T1<3 would go negative after the -2 adjust
         err = (mag == 16'd0) || (first && t1 != 2'd3 && mag == 16'd1) ||
               (suflen == 4'd12 && sfx[15:12] != 4'd0);
      end
      sl_one  = (sl == 3'd0) ? 3'd1 : sl;
      thresh  = 16'd3 << (sl_one - 3'd1);
      sl_next = (mag > thresh && sl_one < SL_MAX) ? sl_one + 3'd1 : sl_one;
   end

   // Block sequencing, output register and adaptive suffixLength
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         tc        <= '0;
         cnt       <= '0;
         t1        <= '0;
         sl        <= '0;
         CodeOut   <= '0;
         CodeLen   <= '0;
         CodeValid <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         LevelErr  <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  tc       <= TotalCoeff;
                  t1       <= TrailingOnes;
                  cnt      <= '0;
                  Busy     <= 1'b1;
                  LevelErr <= 1'b0;
                  sl       <= (TotalCoeff > 5'd10 && TrailingOnes != 2'd3) ? 3'd1 : 3'd0;
                  state    <= (TotalCoeff == 5'd0) ? FLUSH : RUN;
               end
            end
            RUN: begin
               if (CodeValid && CodeReady)
                  CodeValid <= 1'b0;
               if (take) begin
                  cnt <= cnt + 5'd1;
                  if (err) begin
                     LevelErr <= 1'b1;
                  end else begin
                     CodeValid <= 1'b1;
                     CodeOut   <= {12'd0, val};
                     CodeLen   <= len;
                     if (!is_t1)
                        sl <= sl_next;
                  end
                  if ((cnt + 5'd1) == tc)
                     state <= FLUSH;
               end
            end
            FLUSH: begin
               if (!CodeValid || CodeReady) begin
                  CodeValid <= 1'b0;
                  Done      <= 1'b1;
                  Busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cavlc_level_encode.sv
// Scoreboard bench for cavlc_level_encode: a bench-side level model pushes the
// expected codeword whenever a level is accepted; a monitor compares each
// presented codeword against the queue head and pops it on acceptance.
module tb_cavlc_level_encode;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [4:0]  TotalCoeff = '0;
   logic [1:0]  TrailingOnes = '0;
   logic [12:0] LevelIn = '0;
   logic        LevelValid = 1'b0;
   logic        LevelRdy;
   logic [27:0] CodeOut;
   logic [4:0]  CodeLen;
   logic        CodeValid;
   logic        CodeReady;
   logic        Busy;
   logic        Done;
   logic        LevelErr;

   typedef struct {
      logic [27:0] code;
      logic [4:0]  len;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   int          cyc = 0;
   int          last_acc = -1;
   int          start_cyc = 0;
   int          stall_cnt = 0;
   int          m_t1, m_idx, m_sl;
   bit          m_err;

   cavlc_level_encode #(.MAX_SUFFIX_LEN(6)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .TotalCoeff(TotalCoeff),
      .TrailingOnes(TrailingOnes), .LevelIn(LevelIn), .LevelValid(LevelValid),
      .LevelRdy(LevelRdy), .CodeOut(CodeOut), .CodeLen(CodeLen),
      .CodeValid(CodeValid), .CodeReady(CodeReady), .Busy(Busy), .Done(Done),
      .LevelErr(LevelErr)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Bench reference model of one accepted level
   task automatic model_level(input int lvl);
      int a, lc, pre, slen, sfx, base;
      bit err;
      a = (lvl < 0) ? -lvl : lvl;
      if (m_idx < m_t1) begin
         if (a != 1) m_err = 1;
         else exp_q.push_back(exp_t'{code: 28'(lvl < 0), len: 5'd1});
      end else begin
         lc = (lvl > 0) ? 2 * lvl - 2 : -2 * lvl - 1;
         if (m_idx == m_t1 && m_t1 < 3) lc -= 2;
         err = (lvl == 0) || (lc < 0);
         pre = 0; slen = 0; sfx = 0;
         if (m_sl == 0) begin
            if (lc < 14) pre = lc;
            else if (lc < 30) begin pre = 14; slen = 4; sfx = lc - 14; end
            else begin pre = 15; slen = 12; sfx = lc - 30; end
         end else begin
            base = 15 * (1 << m_sl);
            if (lc < base) begin pre = lc / (1 << m_sl); slen = m_sl; sfx = lc % (1 << m_sl); end
            else begin pre = 15; slen = 12; sfx = lc - base; end
         end
         if (slen == 12 && sfx >= 4096) err = 1;
         if (err) m_err = 1;
         else begin
            exp_q.push_back(exp_t'{code: 28'((1 << slen) + sfx), len: 5'(pre + 1 + slen)});
            if (m_sl == 0) m_sl = 1;
            if (a > 3 * (1 << (m_sl - 1)) && m_sl < 6) m_sl++;
         end
      end
      m_idx++;
   endtask

   // Packer model: CodeReady low while a stall is requested and a code is pending
   initial begin
      CodeReady = 1'b1;
      forever begin
         @(posedge Clk);
         #1;
         if (stall_cnt > 0 && CodeValid) begin
            CodeReady = 1'b0;
            stall_cnt--;
         end else begin
            CodeReady = 1'b1;
         end
      end
   end

   // Monitor: every presented code must match the scoreboard head
   initial forever begin
      @(negedge Clk);
      if (!Reset && CodeValid) begin
         if (exp_q.size() == 0) begin
            check("code_unexpected", exp_q.size(), 1);
         end else begin
            check("code", CodeOut, exp_q[0].code);
            check("len", CodeLen, exp_q[0].len);
            if (CodeReady) begin
               void'(exp_q.pop_front());
               last_acc = cyc;
            end else begin
               check("stall_levelrdy", LevelRdy, 0);
            end
         end
      end
   end

   task automatic start_block(input int tc, input int t1);
      Start = 1'b1;
      TotalCoeff = 5'(tc);
      TrailingOnes = 2'(t1);
      m_t1 = t1; m_idx = 0; m_err = 0;
      m_sl = (tc > 10 && t1 < 3) ? 1 : 0;
      start_cyc = cyc;
      @(negedge Clk);
      Start = 1'b0;
      check("busy_start", Busy, 1);
   endtask

   task automatic drive_level(input int lvl, output bit ok);
      int n;
      n = 0;
      LevelIn = 13'(lvl);
      LevelValid = 1'b1;
      while (!LevelRdy && n < 50) begin
         @(negedge Clk);
         n++;
      end
      ok = LevelRdy;
      if (ok) begin
         model_level(lvl);
         @(negedge Clk);
      end
      LevelValid = 1'b0;
   endtask

   task automatic wait_done(input bit code_gap, input bit start_gap);
      int n;
      n = 0;
      while (!Done && n < 100) begin
         @(negedge Clk);
         n++;
      end
      check("done_seen", Done, 1);
      if (Done) begin
         if (code_gap) check("done_after_code", cyc - last_acc, 1);
         if (start_gap) check("done_after_start", cyc - start_cyc, 2);
         check("busy_end", Busy, 0);
         check("levelerr", LevelErr, m_err);
         check("queue_empty", exp_q.size(), 0);
         @(negedge Clk);
         check("done_pulse", Done, 0);
      end
   endtask

   task automatic run_block(input int tc, input int t1, input int lv[$], input bit code_gap);
      bit ok;
      start_block(tc, t1);
      foreach (lv[i]) begin
         drive_level(lv[i], ok);
         check("level_accept", ok, 1);
      end
      wait_done(code_gap, tc == 0);
   endtask

   initial begin
      int lv[$];
      bit ok;
      int tc, t1, mg;

      #22;
      check("rst_levelrdy", LevelRdy, 0);
      check("rst_codevalid", CodeValid, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_levelerr", LevelErr, 0);
      check("rst_codeout", CodeOut, 0);
      check("rst_codelen", CodeLen, 0);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);

      lv = '{1, -1, -1, 1, 3};                  run_block(5, 3, lv, 1);
      lv = '{9};                                run_block(1, 0, lv, 1);
      lv = '{20};                               run_block(1, 0, lv, 1);
      lv = '{-3, 4, 5, -7, 12, 30, -2, 100, -50, 6, 1};
      run_block(11, 0, lv, 1);
      lv = {};                                  run_block(0, 0, lv, 0);
      stall_cnt = 5;
      lv = '{7, -8, 9};                         run_block(3, 0, lv, 1);
      lv = '{1, 3, 0};                          run_block(3, 1, lv, 0);
      lv = '{2100};                             run_block(1, 0, lv, 0);

      for (int b = 0; b < 6; b++) begin
         tc = $urandom_range(1, 16);
         t1 = $urandom_range(0, (tc < 3) ? tc : 3);
         lv = {};
         for (int i = 0; i < tc; i++) begin
            if (i < t1) begin
               mg = 1;
            end else begin
               mg = $urandom_range(1, 200);
               if (i == t1 && t1 < 3 && mg == 1) mg = 2;
            end
            lv.push_back($urandom_range(0, 1) ? -mg : mg);
         end
         if (b == 3) stall_cnt = 3;
         run_block(tc, t1, lv, 1);
      end

      // Reset while a code is stalled in the output register
      stall_cnt = 1000;
      start_block(3, 0);
      drive_level(5, ok);
      check("level_accept", ok, 1);
      @(negedge Clk);
      check("pre_reset_valid", CodeValid, 1);
      #2 Reset = 1'b1;
      #1;
      check("mid_rst_codevalid", CodeValid, 0);
      check("mid_rst_levelrdy", LevelRdy, 0);
      check("mid_rst_busy", Busy, 0);
      check("mid_rst_done", Done, 0);
      check("mid_rst_codeout", CodeOut, 0);
      check("mid_rst_codelen", CodeLen, 0);
      exp_q.delete();
      stall_cnt = 0;
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("post_rst_levelrdy", LevelRdy, 0);
      check("post_rst_busy", Busy, 0);

      lv = '{-1, 2};                            run_block(2, 1, lv, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
